// File: rtl/centroid_accumulator.sv
// Frame-level green-pixel centroid engine: accumulates sum(x), sum(y) and a pixel
// count per frame, then runs two serial restoring dividers at each frame boundary.
module centroid_accumulator #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  input  logic       eh_verde,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_start,
  output logic [9:0] centroX,
  output logic [9:0] centroY,
  output logic       centro_valid,
  output logic       done,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int SW = 28;
  localparam int CW = 19;
  localparam logic [9:0]    X_MAX   = 10'(WIDTH - 1);
  localparam logic [9:0]    Y_MAX   = 10'(HEIGHT - 1);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] sum_x, sum_y;
  logic [CW-1:0] cnt, snap_cnt;
  logic [CW-1:0] rem_x, rem_y;
  logic [SW-1:0] div_x, div_y;
  logic [4:0]    iter;
  logic          pix_ok;

  // pix_valid qualifies x/y/eh_verde; there is no ready, so every valid pixel is
  // consumed in the cycle it arrives and the stream is never stalled.
  assign pix_ok = pix_valid && eh_verde && (x <= X_MAX) && (y <= Y_MAX);

  // The pixel coincident with frame_start opens the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (frame_start) begin
      sum_x <= pix_ok ? {18'd0, x} : '0;
      sum_y <= pix_ok ? {18'd0, y} : '0;
      cnt   <= pix_ok ? CW'(1) : '0;
    end else if (pix_ok) begin
      sum_x <= sum_x + {18'd0, x};
      sum_y <= sum_y + {18'd0, y};
      cnt   <= cnt + CW'(1);
    end
  end

  // One restoring step per cycle; on frame_start the first step (quotient bit 27)
  // is taken straight from the closing accumulators.
  logic [CW-1:0] src_rem_x, src_rem_y, divisor;
  logic [SW-1:0] src_div_x, src_div_y;
  logic [CW:0]   trial_x, trial_y, nrem_x, nrem_y;
  logic          ge_x, ge_y;
  logic [SW-1:0] ndiv_x, ndiv_y;
  logic [1:0]    unused_rem_msb;

  always_comb begin
    src_rem_x = frame_start ? '0 : rem_x;
    src_rem_y = frame_start ? '0 : rem_y;
    src_div_x = frame_start ? sum_x : div_x;
    src_div_y = frame_start ? sum_y : div_y;
    divisor   = frame_start ? cnt : snap_cnt;
    trial_x   = {src_rem_x, src_div_x[SW-1]};
    trial_y   = {src_rem_y, src_div_y[SW-1]};
    ge_x      = trial_x >= {1'b0, divisor};
    ge_y      = trial_y >= {1'b0, divisor};
    nrem_x    = ge_x ? (trial_x - {1'b0, divisor}) : trial_x;
    nrem_y    = ge_y ? (trial_y - {1'b0, divisor}) : trial_y;
    ndiv_x    = {src_div_x[SW-2:0], ge_x};
    ndiv_y    = {src_div_y[SW-2:0], ge_y};
  end

  // The remainder stays below the divisor, so the top trial bit is always zero after a step.
  assign unused_rem_msb = {nrem_x[CW], nrem_y[CW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      centroX      <= '0;
      centroY      <= '0;
      centro_valid <= 1'b0;
      snap_cnt     <= '0;
      rem_x        <= '0;
      rem_y        <= '0;
      div_x        <= '0;
      div_y        <= '0;
      iter         <= '0;
    end else begin
      done <= 1'b0;
      if (frame_start) begin
        snap_cnt <= cnt;
        rem_x    <= nrem_x[CW-1:0];
        rem_y    <= nrem_y[CW-1:0];
        div_x    <= ndiv_x;
        div_y    <= ndiv_y;
        iter     <= 5'd27;
        if (cnt >= MIN_CNT) begin
          state <= ST_DIV;
          busy  <= 1'b1;
        end else begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
          centro_valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_DIV: begin
            rem_x <= nrem_x[CW-1:0];
            rem_y <= nrem_y[CW-1:0];
            div_x <= ndiv_x;
            div_y <= ndiv_y;
            iter  <= iter - 5'd1;
            if (iter == 5'd1) state <= ST_DONE;
          end
          ST_DONE: begin
            centroX      <= (div_x > SW'(X_MAX)) ? X_MAX : div_x[9:0];
            centroY      <= (div_y > SW'(Y_MAX)) ? Y_MAX : div_y[9:0];
            centro_valid <= 1'b1;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/centroid_accumulator.md
# centroid_accumulator

Frame-level green-pixel centroid engine. Sits directly downstream of the per-pixel colour detector/interleaver stage: each cycle it takes the green flag and VGA-domain coordinates (`x`, `y`), accumulates Σx, Σy and a pixel count over one frame, and on each frame boundary runs a serial restoring divider. It publishes `centroX`/`centroY` plus a validity flag for the region-select overlay and the smoothing stage.

## Interface
Parameters:
- `WIDTH`, 640, active columns; pixels with `x >= WIDTH` are ignored
- `HEIGHT`, 480, active rows; pixels with `y >= HEIGHT` are ignored
- `MIN_COUNT`, 64, minimum green pixels per frame for a valid centroid

Ports:
- `clk`  in  1  single clock for the whole block (CLOCK_24 domain)
- `rst_n`  in  1  asynchronous, active-low reset
- `pix_valid`  in  1  qualifies `x`/`y`/`eh_verde` this cycle
- `eh_verde`  in  1  current pixel classified green
- `x`  in  10  pixel column
- `y`  in  10  pixel row
- `frame_start`  in  1  one-cycle pulse marking the first cycle of a new frame; already synchronised to `clk`
- `centroX`  out  10  centroid column of the last completed frame
- `centroY`  out  10  centroid row of the last completed frame
- `centro_valid`  out  1  last completed frame had `count >= MIN_COUNT`
- `done`  out  1  one-cycle pulse when the outputs above update
- `busy`  out  1  divider running

## Operation
- Accumulators: `sum_x`, `sum_y` are 28 bits (max 307200·639 < 2^28); `cnt` is 19 bits. All are unsigned and zero-extended. No overflow is possible within the parameter limits.
- Accumulate when `pix_valid && eh_verde && x < WIDTH && y < HEIGHT`: `sum_x += x`, `sum_y += y`, `cnt += 1`.
- On `frame_start`: copy `sum_x`/`sum_y`/`cnt` (excluding the current cycle's pixel) into the snapshot registers. The accumulators load the current pixel's contribution if it qualifies, otherwise 0. That pixel belongs to the new frame.
- FSM states:
  - IDLE:
    - `frame_start` with snapshot `cnt >= MIN_COUNT` → DIV.
    - `frame_start` with `cnt < MIN_COUNT` → stay in IDLE. Pulse `done`, clear `centro_valid`, hold `centroX`/`centroY`.
  - DIV:
    - Two parallel restoring dividers (Σx/cnt, Σy/cnt), 28 iterations, one quotient bit per cycle, MSB first.
    - 5-bit iteration counter runs from 27 down to 0.
    - After the last iteration → DONE.
  - DONE:
    - Register the quotients, saturated to `WIDTH-1`/`HEIGHT-1`. Set `centro_valid`=1, pulse `done`, return to IDLE.
- `frame_start` while in DIV or DONE: abort the current division without updating outputs or pulsing `done`. Take the new snapshot and restart per the IDLE rules.
- Quotient truncates; there is no rounding.
- Reset values: `centroX`=0, `centroY`=0, `centro_valid`=0, `done`=0, `busy`=0. Accumulators and snapshots are 0; FSM is in IDLE.

## Timing
- `frame_start` sampled at edge T, valid path: `busy`=1 from T+1 through T+28. Outputs and `done` are registered at T+29; `busy`=0 at T+29.
- `frame_start` at T, below threshold: `done`=1 and `centro_valid`=0 at T+1; `busy` stays 0.
- Accumulation is single-cycle with no stall, and the block never back-pressures the pixel stream.
- `centroX`, `centroY` and `centro_valid` change only in the cycle `done` is asserted. Consumers sample on `done` or at any time thereafter.
- `rst_n` asserted mid-DIV: immediate return to reset values. The first `frame_start` after release snapshots the partial frame accumulated since release.

## Test plan
- Reset: hold `rst_n`=0, drive pixels → all outputs 0, `done` never pulses; after release with no `frame_start` → outputs stay 0.
- Square blob: green at x=100..109, y=50..59 (100 px), then `frame_start` at T → `busy` from T+1 to T+28, `done` at T+29, `centroX`=104, `centroY`=54, `centro_valid`=1.
- Below threshold: next frame has 10 green px at x=500 → `done` at T+1, `centro_valid`=0, `centroX`=104 held.
- Boundary filter: green pixels at x=700 (or y=500) plus 64 px at x=639, y=479 → result 639/479, out-of-range pixels ignored; `frame_start` coincident with a green pixel at x=10 → pixel excluded from the closing frame, counted in the next.
- Restart: `frame_start` again 10 cycles into DIV → no `done` for the first frame, `done` 29 cycles after the second pulse with the second frame's centroid.
- Async reset mid-DIV at cycle T+15 → outputs drop to 0 without waiting for an edge; no `done` follows.
